mtm_alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one mtm ALU core (32-bit A/B, 8-bit CTL frame in, 32-bit C and 8-bit CTL frame out) between NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake, drives the core's operand and control inputs, waits the core's fixed latency, and captures the result. It then returns the result, tagged with the requester index, over a backpressured response channel. Sits between the UART deserialiser/command front-ends and mtm_Alu_core.

---
 rtl/mtm_alu_arbiter_if.sv | 38 +++
 rtl/mtm_alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_mtm_alu_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_arbiter_if.sv
// Bus bundle between the mtm ALU arbiter, its requesters, the shared ALU core and the
// response consumer. The arbiter uses the slave view; the environment uses the master view.
interface mtm_alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [8*NUM_REQ-1:0]  req_ctl;

    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [7:0]            alu_ctl;
    logic [31:0]           alu_c;
    logic [7:0]            alu_ctl_out;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_c;
    logic [7:0]            rsp_ctl;
    logic                  rsp_err;
    logic [15:0]           err_count;

    modport slave (
        input  req_valid, req_a, req_b, req_ctl, alu_c, alu_ctl_out, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctl, rsp_valid, rsp_id, rsp_c, rsp_ctl,
               rsp_err, err_count
    );

    modport master (
        output req_valid, req_a, req_b, req_ctl, alu_c, alu_ctl_out, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctl, rsp_valid, rsp_id, rsp_c, rsp_ctl,
               rsp_err, err_count
    );
endinterface

// File: rtl/mtm_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one mtm ALU core between NUM_REQ requesters.
// Define MTM_ALU_ARB_ERRCNT_EN to enable the saturating error-response counter on err_count.
module mtm_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    mtm_alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [ID_W-1:0]    r_ptr;
    logic [2:0]         r_cnt;
    logic [31:0]        r_aluA;
    logic [31:0]        r_aluB;
    logic [7:0]         r_aluCtl;
    logic               r_rspValid;
    logic [ID_W-1:0]    r_rspId;
    logic [31:0]        r_rspC;
    logic [7:0]         r_rspCtl;
    logic               r_rspErr;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grantIdx;
    logic               w_found;
    logic               w_accept;
    logic [31:0]        w_selA;
    logic [31:0]        w_selB;
    logic [7:0]         w_selCtl;

    // Search starts one past the last winner so every waiting requester gets a turn.
    always_comb begin
        int idx;
        w_grant    = '0;
        w_grantIdx = '0;
        w_found    = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && bus.req_valid[idx]) begin
                w_found      = 1'b1;
                w_grant[idx] = 1'b1;
                w_grantIdx   = ID_W'(idx);
            end
        end
    end

    assign w_accept  = (r_state == IDLE) && rst_n && w_found;
    assign w_selA    = bus.req_a[32*w_grantIdx +: 32];
    assign w_selB    = bus.req_b[32*w_grantIdx +: 32];
    assign w_selCtl  = bus.req_ctl[8*w_grantIdx +: 8];

    // Gated by rst_n so no requester sees an accept that reset would discard.
    assign bus.req_ready = ((r_state == IDLE) && rst_n) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_found)          w_nextState = EXEC;
            EXEC:    if (r_cnt == 3'd0)    w_nextState = RESP;
            RESP:    if (bus.rsp_ready)    w_nextState = IDLE;
            default:                       w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_cnt      <= 3'd0;
            r_aluA     <= 32'd0;
            r_aluB     <= 32'd0;
            r_aluCtl   <= 8'hFF;
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspC     <= 32'd0;
            r_rspCtl   <= 8'hFF;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ptr    <= w_grantIdx;
                        r_rspId  <= w_grantIdx;
                        r_aluA   <= w_selA;
                        r_aluB   <= w_selB;
                        r_aluCtl <= w_selCtl;
                        r_cnt    <= 3'(ALU_LAT);
                    end
                end
                EXEC: begin
                    if (r_cnt == 3'd0) begin
                        r_rspC     <= bus.alu_c;
                        r_rspCtl   <= bus.alu_ctl_out;
                        r_rspErr   <= bus.alu_ctl_out[7];
                        r_rspValid <= 1'b1;
                        r_aluCtl   <= 8'hFF;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a     = r_aluA;
    assign bus.alu_b     = r_aluB;
    assign bus.alu_ctl   = r_aluCtl;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_id    = r_rspId;
    assign bus.rsp_c     = r_rspC;
    assign bus.rsp_ctl   = r_rspCtl;
    // Tracks bit 7 of the captured frame, but stays low until the first capture.
    assign bus.rsp_err   = r_rspErr;

`ifdef MTM_ALU_ARB_ERRCNT_EN
    logic [15:0] r_errCount;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_errCount <= 16'h0000;
        end else if (r_rspValid && bus.rsp_ready && r_rspErr && (r_errCount != 16'hFFFF)) begin
            r_errCount <= r_errCount + 16'd1;
        end
    end

    assign bus.err_count = r_errCount;
`else
    assign bus.err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mtm_alu_arbiter.sv
// Directed bench for mtm_alu_arbiter: one DUT with ALU_LAT=1 and one with ALU_LAT=3,
// each driving a small behavioural model of the mtm ALU core.
module tb_mtm_alu_arbiter;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   bit   mon1;
   int   gq[$];
   logic [33:0] rq[$];

   mtm_alu_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus1 ();
   mtm_alu_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus3 ();

   mtm_alu_arbiter #(.NUM_REQ(4), .ID_W(2), .ALU_LAT(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   mtm_alu_arbiter #(.NUM_REQ(4), .ID_W(2), .ALU_LAT(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   // Free-running clock, rising edge is the active edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural core: error/idle frames echo with C=0; otherwise result plus a frame
   // whose low nibble is inverted so a forwarded input frame is distinguishable.
   function automatic logic [39:0] coreModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [7:0] ctl);
      logic [31:0] c;
      c = 32'd0;
      if (ctl[7]) return {ctl, 32'd0};
      case (ctl[6:4])
         3'b000:  c = a & b;
         3'b001:  c = a | b;
         3'b100:  c = a + b;
         3'b101:  c = b - a;
         default: c = 32'd0;
      endcase
      return {1'b0, ctl[6:4], ~ctl[3:0], c};
   endfunction

   // Core pipelines of depth 1 and 3 feeding the two DUTs.
   logic [39:0] pipe1;
   logic [39:0] pipe3 [3];
   always @(posedge clk) begin
      pipe1    <= coreModel(bus1.alu_a, bus1.alu_b, bus1.alu_ctl);
      pipe3[0] <= coreModel(bus3.alu_a, bus3.alu_b, bus3.alu_ctl);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign bus1.alu_c       = pipe1[31:0];
   assign bus1.alu_ctl_out = pipe1[39:32];
   assign bus3.alu_c       = pipe3[2][31:0];
   assign bus3.alu_ctl_out = pipe3[2][39:32];

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Raise valid on requester idx of DUT 'which' with the given operation.
   task automatic applyStimulus(input int which, input int idx, input logic [31:0] a,
                                input logic [31:0] b, input logic [7:0] ctl);
      if (which == 1) begin
         bus1.req_a[32*idx +: 32] = a;
         bus1.req_b[32*idx +: 32] = b;
         bus1.req_ctl[8*idx +: 8] = ctl;
         bus1.req_valid[idx]      = 1'b1;
      end else begin
         bus3.req_a[32*idx +: 32] = a;
         bus3.req_b[32*idx +: 32] = b;
         bus3.req_ctl[8*idx +: 8] = ctl;
         bus3.req_valid[idx]      = 1'b1;
      end
   endtask

   // Pulse reset for two edges with all requests dropped; returns just after an edge.
   task automatic applyReset();
      rst_n          = 1'b0;
      bus1.req_valid = '0;
      bus3.req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic waitGrant(input int which, input int idx, input string tag);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 50) begin
         @(negedge clk);
         hit = (which == 1) ? bus1.req_ready[idx] : bus3.req_ready[idx];
         n++;
      end
      checkOutput(tag, 64'(hit), 64'd1);
   endtask

   task automatic waitRsp(input int which, input string tag);
      int   n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      while (!hit && n < 50) begin
         @(negedge clk);
         hit = (which == 1) ? bus1.rsp_valid : bus3.rsp_valid;
         n++;
      end
      checkOutput(tag, 64'(hit), 64'd1);
   endtask

   // Grant/response recorders and per-cycle arbitration invariants on DUT 1.
   always @(negedge clk) begin
      if (mon1) begin
         for (int i = 0; i < 4; i++) begin
            if (bus1.req_valid[i] && bus1.req_ready[i]) gq.push_back(i);
         end
         if (bus1.rsp_valid && bus1.rsp_ready) rq.push_back({bus1.rsp_id, bus1.rsp_c});
         checkOutput("rr_onehot", 64'($countones(bus1.req_ready) <= 1), 64'd1);
         checkOutput("rr_idle_only", 64'(bus1.rsp_valid && (bus1.req_ready != '0)), 64'd0);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] expErr;
`ifdef MTM_ALU_ARB_ERRCNT_EN
      expErr = 16'd1;
`else
      expErr = 16'd0;
`endif
      checks    = 0;
      failures  = 0;
      mon1      = 1'b0;
      rst_n     = 1'b0;
      bus1.req_valid = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_ctl = '0;
      bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_ctl = '0;
      bus1.rsp_ready = 1'b0;
      bus3.rsp_ready = 1'b1;

      // Reset values.
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", 64'(bus1.req_ready), 64'h0);
      checkOutput("rst_alu_a",     64'(bus1.alu_a),     64'h0);
      checkOutput("rst_alu_b",     64'(bus1.alu_b),     64'h0);
      checkOutput("rst_alu_ctl",   64'(bus1.alu_ctl),   64'hFF);
      checkOutput("rst_rsp_valid", 64'(bus1.rsp_valid), 64'h0);
      checkOutput("rst_rsp_id",    64'(bus1.rsp_id),    64'h0);
      checkOutput("rst_rsp_c",     64'(bus1.rsp_c),     64'h0);
      checkOutput("rst_rsp_ctl",   64'(bus1.rsp_ctl),   64'hFF);
      checkOutput("rst_rsp_err",   64'(bus1.rsp_err),   64'h0);
      checkOutput("rst_err_count", 64'(bus1.err_count), 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single ADD from requester 0: 3 + 5.
      bus1.rsp_ready = 1'b1;
      applyStimulus(1, 0, 32'd3, 32'd5, 8'h40);
      waitGrant(1, 0, "single_grant");
      checkOutput("single_ready_vec", 64'(bus1.req_ready), 64'h1);
      @(posedge clk);
      #1 bus1.req_valid = '0;
      @(negedge clk);
      checkOutput("single_alu_a",   64'(bus1.alu_a),     64'd3);
      checkOutput("single_alu_b",   64'(bus1.alu_b),     64'd5);
      checkOutput("single_alu_ctl", 64'(bus1.alu_ctl),   64'h40);
      checkOutput("single_early1",  64'(bus1.rsp_valid), 64'd0);
      @(negedge clk);
      checkOutput("single_early2",  64'(bus1.rsp_valid), 64'd0);
      @(negedge clk);
      checkOutput("single_valid",   64'(bus1.rsp_valid), 64'd1);
      checkOutput("single_id",      64'(bus1.rsp_id),    64'd0);
      checkOutput("single_c",       64'(bus1.rsp_c),     64'd8);
      checkOutput("single_ctl",     64'(bus1.rsp_ctl),   64'h4F);
      checkOutput("single_err",     64'(bus1.rsp_err),   64'd0);
      checkOutput("single_idlectl", 64'(bus1.alu_ctl),   64'hFF);
      @(negedge clk);
      checkOutput("single_done",    64'(bus1.rsp_valid), 64'd0);

      // Round robin with all four requesters holding valid.
      @(posedge clk);
      #1;
      applyReset();
      gq.delete();
      rq.delete();
      mon1 = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1, i, 32'(i + 1), 32'(10 * (i + 1)), 8'h40);
      for (int n = 0; n < 100 && gq.size() < 5; n++) @(negedge clk);
      mon1 = 1'b0;
      @(posedge clk);
      #1 bus1.req_valid = '0;
      checkOutput("rr_count", 64'(gq.size() >= 5), 64'd1);
      checkOutput("rr_g0", 64'(gq[0]), 64'd0);
      checkOutput("rr_g1", 64'(gq[1]), 64'd1);
      checkOutput("rr_g2", 64'(gq[2]), 64'd2);
      checkOutput("rr_g3", 64'(gq[3]), 64'd3);
      checkOutput("rr_g4", 64'(gq[4]), 64'd0);
      checkOutput("rr_rsp_count", 64'(rq.size() >= 4), 64'd1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rr_rsp%0d", i), 64'(rq[i]), 64'({2'(i), 32'(11 * (i + 1))}));
      end

      // Backpressure: requester 1 SUB (2 - 7) held 5 cycles, requester 3 waiting.
      applyReset();
      bus1.rsp_ready = 1'b0;
      applyStimulus(1, 1, 32'd7, 32'd2, 8'h50);
      applyStimulus(1, 3, 32'd1, 32'd1, 8'h40);
      waitRsp(1, "bp_rsp");
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_c",     64'(bus1.rsp_c),     64'hFFFF_FFFB);
         checkOutput("bp_ctl",   64'(bus1.rsp_ctl),   64'h5F);
         checkOutput("bp_id",    64'(bus1.rsp_id),    64'd1);
         checkOutput("bp_valid", 64'(bus1.rsp_valid), 64'd1);
         checkOutput("bp_ready", 64'(bus1.req_ready), 64'h0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus1.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_hold_valid", 64'(bus1.rsp_valid), 64'd1);
      checkOutput("bp_hold_ready", 64'(bus1.req_ready), 64'h0);
      @(negedge clk);
      checkOutput("bp_release",    64'(bus1.rsp_valid), 64'd0);
      checkOutput("bp_next_grant", 64'(bus1.req_ready), 64'h8);

      // Error frame from requester 2.
      @(posedge clk);
      #1;
      applyReset();
      bus1.rsp_ready = 1'b0;
      applyStimulus(1, 2, 32'd1, 32'd2, 8'hA5);
      waitGrant(1, 2, "err_grant");
      @(posedge clk);
      #1 bus1.req_valid = '0;
      @(negedge clk);
      checkOutput("err_alu_ctl", 64'(bus1.alu_ctl), 64'hA5);
      waitRsp(1, "err_rsp");
      checkOutput("err_ctl",  64'(bus1.rsp_ctl),   64'hA5);
      checkOutput("err_flag", 64'(bus1.rsp_err),   64'd1);
      checkOutput("err_id",   64'(bus1.rsp_id),    64'd2);
      checkOutput("err_cnt0", 64'(bus1.err_count), 64'd0);
      @(posedge clk);
      #1 bus1.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("err_accept", 64'(bus1.rsp_valid), 64'd0);
      checkOutput("err_cnt1",   64'(bus1.err_count), 64'(expErr));

      // Reset one cycle after a handshake by requester 1.
      @(posedge clk);
      #1;
      applyReset();
      applyStimulus(1, 1, 32'd4, 32'd4, 8'h40);
      waitGrant(1, 1, "mid_grant");
      @(posedge clk);
      #1;
      rst_n          = 1'b0;
      bus1.req_valid = '0;
      applyStimulus(1, 0, 32'd2, 32'd2, 8'h40);
      applyStimulus(1, 2, 32'd9, 32'd9, 8'h40);
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid_alu_ctl", 64'(bus1.alu_ctl),   64'hFF);
      checkOutput("mid_valid",   64'(bus1.rsp_valid), 64'd0);
      checkOutput("mid_ready",   64'(bus1.req_ready), 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("mid_regrant", 64'(bus1.req_ready), 64'h1);
      @(posedge clk);
      #1 bus1.req_valid = '0;
      waitRsp(1, "mid_rsp");
      checkOutput("mid_rsp_id", 64'(bus1.rsp_id), 64'd0);
      checkOutput("mid_rsp_c",  64'(bus1.rsp_c),  64'd4);

      // ALU_LAT=3 instance: SUB 10 - 3.
      @(posedge clk);
      #1;
      applyReset();
      bus3.rsp_ready = 1'b1;
      applyStimulus(3, 0, 32'd3, 32'd10, 8'h50);
      waitGrant(3, 0, "lat3_grant");
      @(posedge clk);
      #1 bus3.req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput($sformatf("lat3_a%0d", i),     64'(bus3.alu_a),     64'd3);
         checkOutput($sformatf("lat3_b%0d", i),     64'(bus3.alu_b),     64'd10);
         checkOutput($sformatf("lat3_ctl%0d", i),   64'(bus3.alu_ctl),   64'h50);
         checkOutput($sformatf("lat3_early%0d", i), 64'(bus3.rsp_valid), 64'd0);
      end
      @(negedge clk);
      checkOutput("lat3_valid",   64'(bus3.rsp_valid), 64'd1);
      checkOutput("lat3_c",       64'(bus3.rsp_c),     64'd7);
      checkOutput("lat3_ctl",     64'(bus3.rsp_ctl),   64'h5F);
      checkOutput("lat3_idlectl", 64'(bus3.alu_ctl),   64'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
